// File: rtl/mem_responder_if.sv
// Memory port bundle between the multicycle CPU and the memory responder.
// The CPU drives the request side; the responder returns data and the
// completion handshake.
interface mem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  // CPU side: issues requests and waits for ready
  modport master (
    output addr, wdata, mem_read, mem_write,
    input  rdata, ready, busy, err
  );

  // Memory side: samples requests and answers them
  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output rdata, ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed unified instruction/data RAM with programmable access
// latency. Each request is answered by a one-cycle ready pulse. Malformed
// requests get a one-cycle err pulse alongside ready. Malformed means both
// ops at once, or a byte address that is not word aligned.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input logic      clk,
  input logic      rst,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  LAT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                isWrite_q, isWrite_d;
  logic [31:0]         rdata_q;
  logic                access;
  logic                accessEn;
  logic                reqValid;
  logic                reqBad;
  logic [31:0]         ram_q [DEPTH];

  // Upper address bits only select which alias of the RAM is hit, so they
  // are intentionally dropped; bits [1:0] are used for the alignment check.
  logic unused_addr;
  assign unused_addr = ^bus.addr;

  // A request is anything with either op raised. It is rejected when both
  // ops are raised together or the byte address is not word aligned.
  assign reqValid = bus.mem_read | bus.mem_write;
  assign reqBad   = (bus.mem_read & bus.mem_write) | (bus.addr[1:0] != 2'b00);

  // Next-state and capture logic: decides when the single RAM access fires
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    isWrite_d = isWrite_q;
    access    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (reqBad) begin
            state_d = ERR;
          end else begin
            idx_d     = bus.addr[ADDR_W+1:2];
            wdat_d    = bus.wdata;
            isWrite_d = bus.mem_write;
            if (LAT == 0) begin
              access  = 1'b1;
              state_d = RESP;
            end else begin
              cnt_d   = LAT_LOAD;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is held the FSM still sits in IDLE and could otherwise
  // commit a write on a zero-latency build, so the access is squashed.
  assign accessEn = access & ~rst;

  // Control registers and the read-data holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdat_q    <= 32'd0;
      isWrite_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdat_q    <= wdat_d;
      isWrite_q <= isWrite_d;
      if (access && !isWrite_d) begin
        rdata_q <= ram_q[idx_d];
      end
    end
  end

  // RAM write port; contents survive reset and are never cleared
  always_ff @(posedge clk) begin
    if (accessEn && isWrite_d) begin
      ram_q[idx_d] <= wdat_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == RESP) || (state_q == ERR);
  assign bus.err   = (state_q == ERR);
  assign bus.busy  = (state_q != IDLE);

  // err never appears without its accompanying ready
  property pErrWithReady;
    @(posedge clk) disable iff (rst) bus.err |-> bus.ready;
  endproperty
  assert property (pErrWithReady);

  // ready is always a single-cycle pulse
  property pReadyPulse;
    @(posedge clk) disable iff (rst) bus.ready |=> !bus.ready;
  endproperty
  assert property (pReadyPulse);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with latencies 2, 0
// and 4 share one clock. Each has its own reference RAM model and queue of
// expected responses, checked by an independent monitor.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nChecks = 0;
  int nFail   = 0;

  logic        rstW   [3];
  logic [31:0] addrW  [3];
  logic [31:0] wdataW [3];
  logic        rdW    [3];
  logic        wrW    [3];
  logic [31:0] rdataW [3];
  logic        readyW [3];
  logic        busyW  [3];
  logic        errW   [3];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  assign bus0.addr = addrW[0];  assign bus0.wdata = wdataW[0];
  assign bus0.mem_read = rdW[0]; assign bus0.mem_write = wrW[0];
  assign bus1.addr = addrW[1];  assign bus1.wdata = wdataW[1];
  assign bus1.mem_read = rdW[1]; assign bus1.mem_write = wrW[1];
  assign bus2.addr = addrW[2];  assign bus2.wdata = wdataW[2];
  assign bus2.mem_read = rdW[2]; assign bus2.mem_write = wrW[2];

  assign rdataW[0] = bus0.rdata; assign readyW[0] = bus0.ready;
  assign busyW[0]  = bus0.busy;  assign errW[0]   = bus0.err;
  assign rdataW[1] = bus1.rdata; assign readyW[1] = bus1.ready;
  assign busyW[1]  = bus1.busy;  assign errW[1]   = bus1.err;
  assign rdataW[2] = bus2.rdata; assign readyW[2] = bus2.ready;
  assign busyW[2]  = bus2.busy;  assign errW[2]   = bus2.err;

  mem_responder #(.ADDR_W(8), .LAT(2)) dut0 (.clk(clk), .rst(rstW[0]), .bus(bus0.slave));
  mem_responder #(.ADDR_W(8), .LAT(0)) dut1 (.clk(clk), .rst(rstW[1]), .bus(bus1.slave));
  mem_responder #(.ADDR_W(8), .LAT(4)) dut2 (.clk(clk), .rst(rstW[2]), .bus(bus2.slave));

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
  endfunction

  typedef struct {
    logic        isErr;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t        expQ     [3][$];
  logic [31:0] modelMem [3][256];
  logic [31:0] lastRd   [3];

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d: got %h, want %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (readyW[d] === 1'b1) begin
        if (expQ[d].size() == 0) begin
          checkOutput("unexpected ready", d, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ[d].pop_front();
          checkOutput("ready cycle", d, 32'(cyc), 32'(e.cycle));
          checkOutput("err", d, {31'd0, errW[d]}, {31'd0, e.isErr});
          checkOutput("rdata", d, rdataW[d], e.data);
          checkOutput("busy at ready", d, {31'd0, busyW[d]}, 32'd1);
        end
      end else if (errW[d] === 1'b1) begin
        checkOutput("err without ready", d, 32'd1, 32'd0);
      end
    end
  end

  // Issue one request (called just after a rising edge), hold it until
  // ready, then drop it in the following cycle. With scramble set the
  // address and write data are randomised while the access is in flight.
  task automatic applyStimulus(input int d, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit scramble);
    int   issue;
    bit   got;
    exp_t e;
    addrW[d]  = a;
    wdataW[d] = wd;
    rdW[d]    = rd;
    wrW[d]    = wr;
    issue     = cyc;
    if ((rd && wr) || (a[1:0] != 2'b00)) begin
      e.isErr = 1'b1;
      e.data  = lastRd[d];
      e.cycle = issue + 1;
    end else begin
      e.isErr = 1'b0;
      e.cycle = issue + latOf(d) + 1;
      if (wr) begin
        modelMem[d][a[9:2]] = wd;
      end else begin
        lastRd[d] = modelMem[d][a[9:2]];
      end
      e.data = lastRd[d];
    end
    expQ[d].push_back(e);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (readyW[d] === 1'b1) begin
        got = 1'b1;
      end else if (scramble && cyc > issue) begin
        addrW[d]  = $urandom;
        wdataW[d] = $urandom;
      end
    end
    if (!got) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL ready timeout dut%0d: got no ready, want ready by cycle %0d", d, e.cycle);
    end
    @(posedge clk);
    #1;
    rdW[d] = 1'b0;
    wrW[d] = 1'b0;
  endtask

  task automatic randomOp(input int d);
    int          r;
    logic [31:0] a;
    logic        rd, wr;
    r = $urandom_range(0, 15);
    a = $urandom & 32'h0000_0FFF;
    if (r != 1) a[1:0] = 2'b00;
    else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
    if (r == 0) begin
      rd = 1'b1; wr = 1'b1;
    end else begin
      rd = $urandom_range(0, 1);
      wr = ~rd;
    end
    applyStimulus(d, rd, wr, a, $urandom, ($urandom_range(0, 1) == 1));
  endtask

  task automatic checkResetOutputs(input int d);
    checkOutput("reset rdata", d, rdataW[d], 32'd0);
    checkOutput("reset ready", d, {31'd0, readyW[d]}, 32'd0);
    checkOutput("reset err",   d, {31'd0, errW[d]},   32'd0);
    checkOutput("reset busy",  d, {31'd0, busyW[d]},  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    for (int d = 0; d < 3; d++) begin
      rstW[d] = 1'b1; addrW[d] = 32'd0; wdataW[d] = 32'd0;
      rdW[d] = 1'b0; wrW[d] = 1'b0; lastRd[d] = 32'd0;
    end
    for (int i = 0; i < 256; i++) begin
      v = $urandom; dut0.ram_q[i] = v; modelMem[0][i] = v;
      v = $urandom; dut1.ram_q[i] = v; modelMem[1][i] = v;
      v = $urandom;
      if (i == 8 && v == 32'h1234_5678) v = 32'h0;
      dut2.ram_q[i] = v; modelMem[2][i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) checkResetOutputs(d);
    for (int d = 0; d < 3; d++) rstW[d] = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] LAT=2 write/read, rejects, wrap");
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h404, 32'hA5A5_A5A5, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    for (int k = 0; k < 40; k++) randomOp(0);

    $display("[TB] LAT=0 streaming");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
    for (int k = 0; k < 30; k++) randomOp(1);

    $display("[TB] LAT=4 abort on reset");
    applyStimulus(2, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    addrW[2] = 32'h20; wdataW[2] = 32'h1234_5678; wrW[2] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("busy in wait", 2, {31'd0, busyW[2]}, 32'd1);
    #1;
    rstW[2] = 1'b1;
    #1;
    checkResetOutputs(2);
    lastRd[2] = 32'd0;
    wrW[2] = 1'b0;
    @(posedge clk);
    #1;
    rstW[2] = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    for (int k = 0; k < 20; k++) randomOp(2);

    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) checkOutput("responses outstanding", d, 32'(expQ[d].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
